// File: rtl/mem_arbiter.sv
// Two-port arbiter for the unified instruction/data memory.
// Serialises core and loader accesses and applies the fixed read latency.
module mem_arbiter #(
    parameter int MEM_LAT  = 2,
    parameter bit PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_wstrb,
    output logic        c_gnt,
    output logic        c_done,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        owner;
    logic        rr_last;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;
    logic        grant;
    logic        win;

    // win: 0 selects the core, 1 selects the loader
    always_comb begin
        win = 1'b0;
        unique case (1'b1)
            c_req && !d_req: win = 1'b0;
            d_req && !c_req: win = 1'b1;
            default:         win = PRIORITY ? 1'b0 : ~rr_last;
        endcase
    end

    assign grant = (state == IDLE) && (c_req || d_req) && !rst;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = (MEM_LAT == 1) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            owner     <= 1'b0;
            rr_last   <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
        end else begin
            if (grant) begin
                owner     <= win;
                lat_we    <= win ? d_we    : c_we;
                lat_addr  <= win ? d_addr  : c_addr;
                lat_wdata <= win ? d_wdata : c_wdata;
                lat_wstrb <= win ? d_wstrb : c_wstrb;
            end
            if (state == ISSUE)     cnt <= 4'(MEM_LAT - 1);
            else if (state == WAIT) cnt <= cnt - 4'd1;
            if (state == RESP)      rr_last <= owner;
        end
    end

    // Strobes are suppressed while rst is high so an abandoned access never completes
    always_comb begin
        c_gnt   = 1'b0;
        d_gnt   = 1'b0;
        c_done  = 1'b0;
        d_done  = 1'b0;
        c_rdata = '0;
        d_rdata = '0;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        if (grant) begin
            c_gnt = ~win;
            d_gnt = win;
        end
        if (state == RESP && !rst) begin
            c_done = ~owner;
            d_done = owner;
            if (!lat_we && !owner) c_rdata = mem_rdata;
            if (!lat_we && owner)  d_rdata = mem_rdata;
        end
        if (state == ISSUE && !rst) begin
            mem_en = 1'b1;
            mem_we = lat_we;
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_wstrb = lat_wstrb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios on three configurations
// plus a randomized run against a cycle-arithmetic reference model.
module tb_mem_arbiter;

    localparam int NI = 3;
    localparam int LAT [NI] = '{2, 2, 1};
    localparam bit PRI [NI] = '{1'b0, 1'b1, 1'b0};

    typedef logic [137:0] ovec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        c_req [NI];
    logic        c_we [NI];
    logic [31:0] c_addr [NI];
    logic [31:0] c_wdata [NI];
    logic [3:0]  c_wstrb [NI];
    logic        c_gnt [NI];
    logic        c_done [NI];
    logic [31:0] c_rdata [NI];
    logic        d_req [NI];
    logic        d_we [NI];
    logic [31:0] d_addr [NI];
    logic [31:0] d_wdata [NI];
    logic [3:0]  d_wstrb [NI];
    logic        d_gnt [NI];
    logic        d_done [NI];
    logic [31:0] d_rdata [NI];
    logic        mem_en [NI];
    logic        mem_we [NI];
    logic [31:0] mem_addr [NI];
    logic [31:0] mem_wdata [NI];
    logic [3:0]  mem_wstrb [NI];
    logic [31:0] mem_rdata [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_arbiter #(
            .MEM_LAT (LAT[g]),
            .PRIORITY(PRI[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .c_req    (c_req[g]),
            .c_we     (c_we[g]),
            .c_addr   (c_addr[g]),
            .c_wdata  (c_wdata[g]),
            .c_wstrb  (c_wstrb[g]),
            .c_gnt    (c_gnt[g]),
            .c_done   (c_done[g]),
            .c_rdata  (c_rdata[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_wstrb  (d_wstrb[g]),
            .d_gnt    (d_gnt[g]),
            .d_done   (d_done[g]),
            .d_rdata  (d_rdata[g]),
            .mem_en   (mem_en[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_wstrb(mem_wstrb[g]),
            .mem_rdata(mem_rdata[g])
        );
    end

    function automatic logic [31:0] mdat(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic ovec_t outs(input int i);
        return {c_gnt[i], d_gnt[i], c_done[i], d_done[i],
                c_rdata[i], d_rdata[i], mem_en[i], mem_we[i],
                mem_addr[i], mem_wdata[i], mem_wstrb[i]};
    endfunction

    // Memory: read data appears exactly LAT cycles after mem_en, noise otherwise
    int          rd_due [NI];
    logic [31:0] rd_addr [NI];

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++)
            if (mem_en[i] === 1'b1 && mem_we[i] === 1'b0) begin
                rd_due[i]  <= cyc + LAT[i];
                rd_addr[i] <= mem_addr[i];
            end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++)
            mem_rdata[i] = (cyc == rd_due[i]) ? mdat(rd_addr[i]) : $urandom;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        smp();
        for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (outs(i) !== '0) begin
                n_fail++;
                $display("FAIL reset_held[%0d]: got %h want 0", i, outs(i));
            end
        end
        tick();
        rst = 1'b0;
        smp();
        for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (outs(i) !== '0) begin
                n_fail++;
                $display("FAIL reset_release[%0d]: got %h want 0", i, outs(i));
            end
        end
        tick();
    endtask

    task automatic test_core_read();
        int bad_d = 0;
        c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h100;
        smp();
        n_tests++;
        if ({c_gnt[0], d_gnt[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL core_read gnt: got %b want 10", {c_gnt[0], d_gnt[0]});
        end
        if (d_done[0] !== 1'b0) bad_d++;
        tick();
        c_req[0] = 1'b0;
        smp();
        n_tests++;
        if ({mem_en[0], mem_we[0], mem_addr[0]} !== {2'b10, 32'h100}) begin
            n_fail++;
            $display("FAIL core_read issue: got en=%b we=%b addr=%h want 1 0 100",
                     mem_en[0], mem_we[0], mem_addr[0]);
        end
        if (d_done[0] !== 1'b0) bad_d++;
        tick();
        smp();
        n_tests++;
        if ({mem_en[0], c_done[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL core_read wait: got en=%b done=%b want 0 0", mem_en[0], c_done[0]);
        end
        if (d_done[0] !== 1'b0) bad_d++;
        tick();
        smp();
        n_tests++;
        if ({c_done[0], c_rdata[0]} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL core_read resp: got done=%b rdata=%h want 1 deadbeef",
                     c_done[0], c_rdata[0]);
        end
        if (d_done[0] !== 1'b0) bad_d++;
        tick();
        smp();
        n_tests++;
        if ({c_done[0], c_rdata[0]} !== 33'h0) begin
            n_fail++;
            $display("FAIL core_read after: got done=%b rdata=%h want 0 0", c_done[0], c_rdata[0]);
        end
        n_tests++;
        if (bad_d != 0) begin
            n_fail++;
            $display("FAIL core_read d_done: got %0d pulses want 0", bad_d);
        end
        tick();
    endtask

    task automatic test_write();
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h40;
        d_wdata[0] = 32'h12345678; d_wstrb[0] = 4'b0011;
        smp();
        n_tests++;
        if ({c_gnt[0], d_gnt[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL write gnt: got %b want 01", {c_gnt[0], d_gnt[0]});
        end
        tick();
        d_req[0] = 1'b0;
        smp();
        n_tests++;
        if ({mem_en[0], mem_we[0], mem_wstrb[0], mem_addr[0], mem_wdata[0]} !==
            {2'b11, 4'b0011, 32'h40, 32'h12345678}) begin
            n_fail++;
            $display("FAIL write issue: got en=%b we=%b strb=%b addr=%h wdata=%h",
                     mem_en[0], mem_we[0], mem_wstrb[0], mem_addr[0], mem_wdata[0]);
        end
        tick();
        smp();
        n_tests++;
        if ({mem_en[0], mem_we[0], d_done[0]} !== 3'b000) begin
            n_fail++;
            $display("FAIL write wait: got en=%b we=%b done=%b want 000",
                     mem_en[0], mem_we[0], d_done[0]);
        end
        tick();
        smp();
        n_tests++;
        if ({d_done[0], d_rdata[0], c_done[0]} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL write resp: got d_done=%b d_rdata=%h c_done=%b want 1 0 0",
                     d_done[0], d_rdata[0], c_done[0]);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int k = 0;
        int last = 0;
        int t0;
        int expt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h10;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h20;
        t0 = cyc;
        for (int j = 0; j < 60 && k < 8; j++) begin
            smp();
            if (c_gnt[0] || d_gnt[0]) begin
                n_tests++;
                if (c_gnt[0] && d_gnt[0]) begin
                    n_fail++;
                    $display("FAIL rr both: got 2 grants want 1 at grant %0d", k);
                end else if (d_gnt[0] !== 1'(k % 2)) begin
                    n_fail++;
                    $display("FAIL rr order: got d_gnt=%b want %0d at grant %0d", d_gnt[0], k % 2, k);
                end
                expt = (k == 0) ? t0 : last + 4;
                n_tests++;
                if (cyc != expt) begin
                    n_fail++;
                    $display("FAIL rr timing: got cycle %0d want %0d at grant %0d", cyc, expt, k);
                end
                last = cyc;
                k++;
            end
            tick();
        end
        n_tests++;
        if (k != 8) begin
            n_fail++;
            $display("FAIL rr timeout: got %0d grants want 8", k);
        end
        c_req[0] = 1'b0;
        d_req[0] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_fixed_priority();
        int nc = 0;
        int t20 = -1;
        int td = -1;
        int nd_early = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 32'h80;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h84;
        for (int j = 0; j < 150 && td < 0; j++) begin
            smp();
            if (c_gnt[1]) begin
                nc++;
                if (nc == 20) t20 = cyc;
            end
            if (d_gnt[1]) begin
                if (t20 < 0) nd_early++;
                else td = cyc;
            end
            tick();
            if (t20 >= 0) c_req[1] = 1'b0;
        end
        n_tests++;
        if (nc != 20) begin
            n_fail++;
            $display("FAIL prio core grants: got %0d want 20", nc);
        end
        n_tests++;
        if (nd_early != 0) begin
            n_fail++;
            $display("FAIL prio starved d: got %0d early d grants want 0", nd_early);
        end
        n_tests++;
        if (t20 < 0 || td != t20 + 4) begin
            n_fail++;
            $display("FAIL prio d_gnt: got cycle %0d want %0d", td, t20 + 4);
        end
        d_req[1] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_in_wait();
        ovec_t e;
        int bad_done = 0;
        c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h300;
        smp();
        n_tests++;
        if (c_gnt[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait gnt: got %b want 1", c_gnt[0]);
        end
        tick();
        c_req[0] = 1'b0;
        smp();
        tick();
        rst = 1'b1;
        smp();
        if (c_done[0] !== 1'b0) bad_done++;
        tick();
        rst = 1'b0;
        c_req[0] = 1'b1; c_addr[0] = 32'h200;
        smp();
        e = '0;
        e[137] = 1'b1;
        n_tests++;
        if (outs(0) !== e) begin
            n_fail++;
            $display("FAIL rst_wait after: got %h want %h", outs(0), e);
        end
        tick();
        c_req[0] = 1'b0;
        smp();
        n_tests++;
        if ({mem_en[0], mem_addr[0]} !== {1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL rst_wait reissue: got en=%b addr=%h want 1 200", mem_en[0], mem_addr[0]);
        end
        if (c_done[0] !== 1'b0) bad_done++;
        tick();
        smp();
        if (c_done[0] !== 1'b0) bad_done++;
        n_tests++;
        if (bad_done != 0) begin
            n_fail++;
            $display("FAIL rst_wait stray done: got %0d pulses want 0", bad_done);
        end
        tick();
        smp();
        n_tests++;
        if ({c_done[0], c_rdata[0]} !== {1'b1, mdat(32'h200)}) begin
            n_fail++;
            $display("FAIL rst_wait resp: got done=%b rdata=%h want 1 %h",
                     c_done[0], c_rdata[0], mdat(32'h200));
        end
        tick();
    endtask

    task automatic test_lat1_back_to_back();
        logic [31:0] a;
        a = 32'h1000;
        c_req[2] = 1'b1; c_we[2] = 1'b0; c_addr[2] = a;
        for (int k = 0; k < 6; k++) begin
            smp();
            n_tests++;
            if (c_gnt[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL lat1 gnt %0d: got %b want 1", k, c_gnt[2]);
            end
            tick();
            c_addr[2] = a + 32'h24;
            smp();
            n_tests++;
            if ({mem_en[2], mem_addr[2]} !== {1'b1, a}) begin
                n_fail++;
                $display("FAIL lat1 issue %0d: got en=%b addr=%h want 1 %h", k, mem_en[2], mem_addr[2], a);
            end
            tick();
            smp();
            n_tests++;
            if ({c_done[2], c_rdata[2]} !== {1'b1, mdat(a)}) begin
                n_fail++;
                $display("FAIL lat1 resp %0d: got done=%b rdata=%h want 1 %h",
                         k, c_done[2], c_rdata[2], mdat(a));
            end
            tick();
            a = a + 32'h24;
        end
        c_req[2] = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int          free_at [NI];
        int          issue_at [NI];
        int          done_at [NI];
        bit          own [NI];
        bit          rr [NI];
        logic        lwe [NI];
        logic [31:0] laddr [NI];
        logic [31:0] lwdata [NI];
        logic [3:0]  lwstrb [NI];
        bit          cg [NI];
        bit          dg [NI];
        ovec_t       e;
        ovec_t       msk;
        bit          g;
        bit          w;
        bit          ed;
        bit          ei;
        int          n;
        for (int i = 0; i < NI; i++) begin
            cg[i] = 1'b0;
            dg[i] = 1'b0;
        end
        for (int k = 0; k < 800; k++) begin
            rst = (k == 0) || ($urandom_range(0, 49) == 0);
            for (int i = 0; i < NI; i++) begin
                if (!c_req[i] || cg[i]) begin
                    c_req[i]   = ($urandom_range(0, 2) != 0);
                    c_we[i]    = 1'($urandom_range(0, 1));
                    c_addr[i]  = $urandom & 32'hFFFC;
                    c_wdata[i] = $urandom;
                    c_wstrb[i] = 4'($urandom_range(0, 15));
                end else if ($urandom_range(0, 9) == 0) begin
                    c_req[i] = 1'b0;
                end
                if (!d_req[i] || dg[i]) begin
                    d_req[i]   = ($urandom_range(0, 2) != 0);
                    d_we[i]    = 1'($urandom_range(0, 1));
                    d_addr[i]  = $urandom & 32'hFFFC;
                    d_wdata[i] = $urandom;
                    d_wstrb[i] = 4'($urandom_range(0, 15));
                end else if ($urandom_range(0, 9) == 0) begin
                    d_req[i] = 1'b0;
                end
            end
            smp();
            n = cyc;
            for (int i = 0; i < NI; i++) begin
                cg[i] = c_gnt[i];
                dg[i] = d_gnt[i];
                if (rst) begin
                    e   = '0;
                    msk = {{70{1'b1}}, 68'h0};
                end else begin
                    g  = (n >= free_at[i]) && (c_req[i] || d_req[i]);
                    w  = d_req[i] && (!c_req[i] || (!PRI[i] && !rr[i]));
                    ed = (n == done_at[i]);
                    ei = (n == issue_at[i]);
                    e  = {g && !w, g && w, ed && !own[i], ed && own[i],
                          (ed && !own[i] && !lwe[i]) ? mdat(laddr[i]) : 32'h0,
                          (ed && own[i] && !lwe[i]) ? mdat(laddr[i]) : 32'h0,
                          ei, ei && lwe[i], laddr[i], lwdata[i], lwstrb[i]};
                    msk = '1;
                end
                n_tests++;
                if ((outs(i) & msk) !== (e & msk)) begin
                    n_fail++;
                    $display("FAIL random[%0d] cycle %0d: got %h want %h (rst=%b)",
                             i, n, outs(i) & msk, e & msk, rst);
                end
                if (rst) begin
                    free_at[i]  = n + 1;
                    issue_at[i] = -100;
                    done_at[i]  = -100;
                    rr[i]       = 1'b1;
                    own[i]      = 1'b0;
                    lwe[i]      = 1'b0;
                    laddr[i]    = '0;
                    lwdata[i]   = '0;
                    lwstrb[i]   = '0;
                end else if (g) begin
                    own[i]      = w;
                    rr[i]       = w;
                    lwe[i]      = w ? d_we[i] : c_we[i];
                    laddr[i]    = w ? d_addr[i] : c_addr[i];
                    lwdata[i]   = w ? d_wdata[i] : c_wdata[i];
                    lwstrb[i]   = w ? d_wstrb[i] : c_wstrb[i];
                    issue_at[i] = n + 1;
                    done_at[i]  = n + 1 + LAT[i];
                    free_at[i]  = n + 2 + LAT[i];
                end
            end
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            c_req[i] = 1'b0;
            d_req[i] = 1'b0;
        end
        repeat (5) tick();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            c_req[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0;
            c_wdata[i] = '0; c_wstrb[i] = '0;
            d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0;
            d_wdata[i] = '0; d_wstrb[i] = '0;
            mem_rdata[i] = '0;
            rd_due[i] = -1;
            rd_addr[i] = '0;
        end
        test_reset();
        test_core_read();
        test_write();
        test_round_robin();
        test_fixed_priority();
        test_reset_in_wait();
        test_lat1_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
